main_fsm_ext: RTL and testbench

Parametrised control FSM for the multi-cycle RV32 core. It extends the base decoder with JALR, the full branch set, an optional RV32M multi-cycle execute path with start/done handshake, and memory wait states. It also adds a sticky illegal-instruction trap and a per-instruction retire strobe. It drives the shared-ALU datapath (PC/OldPC, A/B, ALUOut, Data registers) and plugs into the existing controller in place of the base FSM.

---
 rtl/main_fsm_ext.sv | 234 +++++++++++++++++++++++
 tb/tb_main_fsm_ext.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_fsm_ext.sv
// main_fsm_ext: multi-cycle RV32 control FSM with JALR, the full branch set,
// an optional multi-cycle mul/div path, memory wait states, a sticky illegal
// instruction trap and a per-instruction retire strobe.
module main_fsm_ext #(
   parameter logic MEM_WAIT_EN = 1'b1,
   parameter logic MULDIV_EN   = 1'b1,
   parameter logic TRAP_EN     = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7_0,
   input  logic       mem_ready,
   input  logic       alu_done,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ResultSrc,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCUpdate,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       Branch,
   output logic [2:0] BranchCond,
   output logic       MulDivStart,
   output logic       Trap,
   output logic       InstrRetire,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      ALUWB    = 4'd7,
      EXECI    = 4'd8,
      JAL      = 4'd9,
      BRANCH   = 4'd10,
      UTYPE    = 4'd11,
      JALR     = 4'd12,
      MULDIV   = 4'd13,
      TRAP     = 4'd14,
      LINK     = 4'd15
   } state_t;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   state_t cur_state;
   state_t next_state;
   state_t decode_next;
   logic   start_q;
   logic   mem_ok;

   // With single-cycle memory the ready handshake is ignored entirely.
   assign mem_ok = mem_ready | ~MEM_WAIT_EN;
   assign state  = cur_state;

   // State register, cleared straight to FETCH by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cur_state <= FETCH;
      else        cur_state <= next_state;
   end

   // Start flop marks the first MULDIV cycle so the unit sees a one-cycle pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) start_q <= 1'b0;
      else        start_q <= (cur_state == DECODE) && (next_state == MULDIV);
   end

   // Opcode decode: where DECODE goes next; anything unrecognised is illegal.
   always_comb begin
      if (TRAP_EN) decode_next = TRAP;
      else         decode_next = FETCH;
      case (op)
         OP_LW, OP_SW: decode_next = MEMADR;
         OP_RTYPE: begin
            if (!funct7_0)     decode_next = EXECR;
            else if (MULDIV_EN) decode_next = MULDIV;
         end
         OP_ITYPE:  decode_next = EXECI;
         OP_JAL:    decode_next = JAL;
         OP_JALR:   decode_next = JALR;
         OP_BRANCH: begin
            if (funct3 != 3'b010 && funct3 != 3'b011) decode_next = BRANCH;
         end
         OP_AUIPC, OP_LUI: decode_next = UTYPE;
         default: ;
      endcase
   end

   // Next-state and output decode; every output starts at 0 in every state.
   always_comb begin
      next_state  = cur_state;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      ResultSrc   = 2'b00;
      AdrSrc      = 1'b0;
      IRWrite     = 1'b0;
      PCUpdate    = 1'b0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      Branch      = 1'b0;
      BranchCond  = 3'b000;
      MulDivStart = 1'b0;
      Trap        = 1'b0;
      InstrRetire = 1'b0;
      case (cur_state)
         FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (mem_ok) begin
               IRWrite    = 1'b1;
               PCUpdate   = 1'b1;
               next_state = DECODE;
            end
         end
         DECODE: begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b01;
            next_state = decode_next;
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            if (op == OP_SW) next_state = MEMWRITE;
            else             next_state = MEMREAD;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (mem_ok) next_state = MEMWB;
         end
         MEMWB: begin
            ResultSrc   = 2'b01;
            RegWrite    = 1'b1;
            InstrRetire = 1'b1;
            next_state  = FETCH;
         end
         MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (mem_ok) begin
               InstrRetire = 1'b1;
               next_state  = FETCH;
            end
         end
         EXECR: begin
            ALUSrcA    = 2'b10;
            ALUOp      = 2'b10;
            next_state = ALUWB;
         end
         ALUWB: begin
            RegWrite    = 1'b1;
            InstrRetire = 1'b1;
            next_state  = FETCH;
         end
         EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUOp      = 2'b10;
            next_state = ALUWB;
         end
         JAL: begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            PCUpdate   = 1'b1;
            next_state = ALUWB;
         end
         BRANCH: begin
            ALUSrcA     = 2'b10;
            ALUOp       = 2'b01;
            Branch      = 1'b1;
            BranchCond  = funct3;
            InstrRetire = 1'b1;
            next_state  = FETCH;
         end
         UTYPE: begin
            ALUSrcA    = (op == OP_LUI) ? 2'b11 : 2'b01;
            ALUSrcB    = 2'b01;
            next_state = ALUWB;
         end
         JALR: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ResultSrc  = 2'b10;
            PCUpdate   = 1'b1;
            next_state = LINK;
         end
         MULDIV: begin
            ALUSrcA     = 2'b10;
            ALUOp       = 2'b11;
            MulDivStart = start_q;
            if (alu_done) next_state = ALUWB;
         end
         TRAP: begin
            Trap = 1'b1;
         end
         LINK: begin
            ALUSrcA     = 2'b01;
            ALUSrcB     = 2'b10;
            ResultSrc   = 2'b10;
            RegWrite    = 1'b1;
            InstrRetire = 1'b1;
            next_state  = FETCH;
         end
      endcase
      if (!reset) begin
         next_state  = FETCH;
         IRWrite     = 1'b0;
         PCUpdate    = 1'b0;
         RegWrite    = 1'b0;
         MemWrite    = 1'b0;
         Branch      = 1'b0;
         MulDivStart = 1'b0;
         Trap        = 1'b0;
         InstrRetire = 1'b0;
      end
   end

endmodule

// File: tb/tb_main_fsm_ext.sv
// tb_main_fsm_ext: directed bench for main_fsm_ext. Three instances with
// different parameter sets share the same inputs; expected outputs are queued
// as each cycle is driven and compared once the outputs have settled.
module tb_main_fsm_ext;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_ILL    = 7'b1111111;

   // unit 0: all features on; unit 1: no mem wait, no trap; unit 2: no mem wait, no muldiv
   localparam logic [2:0] MW_CFG = 3'b001;
   localparam logic [2:0] MD_CFG = 3'b011;
   localparam logic [2:0] TR_CFG = 3'b101;

   // strobe bits {IRWrite,PCUpdate,RegWrite,MemWrite,Branch,MulDivStart,Trap,InstrRetire}
   localparam logic [7:0] NONE = 8'h00;
   localparam logic [7:0] IRW  = 8'h80;
   localparam logic [7:0] PCU  = 8'h40;
   localparam logic [7:0] RW   = 8'h20;
   localparam logic [7:0] MW   = 8'h10;
   localparam logic [7:0] BR   = 8'h08;
   localparam logic [7:0] MDS  = 8'h04;
   localparam logic [7:0] TRP  = 8'h02;
   localparam logic [7:0] RET  = 8'h01;

   // mux fields {ALUSrcA,ALUSrcB,ALUOp,ResultSrc,AdrSrc,BranchCond}
   localparam logic [11:0] MX_FETCH  = {2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 3'b000};
   localparam logic [11:0] MX_DECODE = {2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 3'b000};
   localparam logic [11:0] MX_MEMADR = {2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 3'b000};
   localparam logic [11:0] MX_MEMACC = {2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000};
   localparam logic [11:0] MX_MEMWB  = {2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000};
   localparam logic [11:0] MX_EXECR  = {2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 3'b000};
   localparam logic [11:0] MX_EXECI  = {2'b10, 2'b01, 2'b10, 2'b00, 1'b0, 3'b000};
   localparam logic [11:0] MX_ZERO   = 12'h000;
   localparam logic [11:0] MX_JAL    = {2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 3'b000};
   localparam logic [11:0] MX_JALR   = {2'b10, 2'b01, 2'b00, 2'b10, 1'b0, 3'b000};
   localparam logic [11:0] MX_LINK   = {2'b01, 2'b10, 2'b00, 2'b10, 1'b0, 3'b000};
   localparam logic [11:0] MX_MULDIV = {2'b10, 2'b00, 2'b11, 2'b00, 1'b0, 3'b000};
   localparam logic [11:0] MX_LUI    = {2'b11, 2'b01, 2'b00, 2'b00, 1'b0, 3'b000};
   localparam logic [11:0] MX_AUIPC  = {2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 3'b000};
   localparam logic [11:0] MX_BGE    = {2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 3'b101};

   typedef struct {
      string       tag;
      int          unit;
      logic [3:0]  st;
      logic [7:0]  strb;
      logic [11:0] mux;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7_0;
   logic       mem_ready;
   logic       alu_done;
   logic [23:0] obs [3];
   exp_t       sb [$];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [1:0] a_src, b_src, alu_op, res_src;
      logic [2:0] br_cond;
      logic [3:0] st;
      logic adr, irw, pcu, rw, mw, br, mds, trp, ret;

      main_fsm_ext #(
         .MEM_WAIT_EN(MW_CFG[g]),
         .MULDIV_EN(MD_CFG[g]),
         .TRAP_EN(TR_CFG[g])
      ) dut (
         .clk(clk),
         .reset(reset),
         .op(op),
         .funct3(funct3),
         .funct7_0(funct7_0),
         .mem_ready(mem_ready),
         .alu_done(alu_done),
         .ALUSrcA(a_src),
         .ALUSrcB(b_src),
         .ALUOp(alu_op),
         .ResultSrc(res_src),
         .AdrSrc(adr),
         .IRWrite(irw),
         .PCUpdate(pcu),
         .RegWrite(rw),
         .MemWrite(mw),
         .Branch(br),
         .BranchCond(br_cond),
         .MulDivStart(mds),
         .Trap(trp),
         .InstrRetire(ret),
         .state(st)
      );

      assign obs[g] = {st, irw, pcu, rw, mw, br, mds, trp, ret,
                       a_src, b_src, alu_op, res_src, adr, br_cond};
   end

   // Drive one cycle of inputs at the falling edge, with reset released.
   task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                                input logic f7, input logic mr, input logic ad);
      @(negedge clk);
      reset     = 1'b1;
      op        = o;
      funct3    = f3;
      funct7_0  = f7;
      mem_ready = mr;
      alu_done  = ad;
   endtask

   task automatic pushExpect(input string tag, input int unit, input logic [3:0] st,
                             input logic [7:0] strb, input logic [11:0] mux);
      exp_t e;
      e.tag  = tag;
      e.unit = unit;
      e.st   = st;
      e.strb = strb;
      e.mux  = mux;
      sb.push_back(e);
   endtask

   // Let outputs settle, then drain the scoreboard against all instances.
   task automatic checkOutput();
      exp_t e;
      logic [23:0] o;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs[e.unit];
         checks++;
         assert (o[23:20] === e.st) else begin
            errors++;
            $error("[TB] FAIL %s.state u%0d: observed %0d expected %0d", e.tag, e.unit, o[23:20], e.st);
         end
         checks++;
         assert (o[19:12] === e.strb) else begin
            errors++;
            $error("[TB] FAIL %s.strobes u%0d: observed %b expected %b", e.tag, e.unit, o[19:12], e.strb);
         end
         checks++;
         assert (o[11:0] === e.mux) else begin
            errors++;
            $error("[TB] FAIL %s.mux u%0d: observed %h expected %h", e.tag, e.unit, o[11:0], e.mux);
         end
      end
   endtask

   task automatic resetAll();
      @(negedge clk);
      reset     = 1'b0;
      mem_ready = 1'b0;
      alu_done  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b0; op = 7'd0; funct3 = 3'd0; funct7_0 = 1'b0;
      mem_ready = 1'b0; alu_done = 1'b0;

      // reset state on all instances, with mem_ready high
      @(negedge clk);
      mem_ready = 1'b1;
      for (int u = 0; u < 3; u++) pushExpect("reset", u, 4'd0, NONE, MX_FETCH);
      checkOutput();

      // lw with three wait cycles in MEMREAD
      applyStimulus(OP_LW, 3'd2, 1'b0, 1'b1, 1'b0); pushExpect("lw_fetch", 0, 4'd0, IRW | PCU, MX_FETCH); checkOutput();
      applyStimulus(OP_LW, 3'd2, 1'b0, 1'b0, 1'b0); pushExpect("lw_decode", 0, 4'd1, NONE, MX_DECODE); checkOutput();
      applyStimulus(OP_LW, 3'd2, 1'b0, 1'b0, 1'b0); pushExpect("lw_memadr", 0, 4'd2, NONE, MX_MEMADR); checkOutput();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(OP_LW, 3'd2, 1'b0, 1'b0, 1'b0); pushExpect("lw_wait", 0, 4'd3, NONE, MX_MEMACC); checkOutput();
      end
      applyStimulus(OP_LW, 3'd2, 1'b0, 1'b1, 1'b0); pushExpect("lw_ready", 0, 4'd3, NONE, MX_MEMACC); checkOutput();
      applyStimulus(OP_LW, 3'd2, 1'b0, 1'b0, 1'b0); pushExpect("lw_memwb", 0, 4'd4, RW | RET, MX_MEMWB); checkOutput();
      applyStimulus(OP_LW, 3'd2, 1'b0, 1'b0, 1'b0); pushExpect("fetch_wait", 0, 4'd0, NONE, MX_FETCH); checkOutput();

      // reset asserted in the middle of MEMREAD
      applyStimulus(OP_LW, 3'd2, 1'b0, 1'b1, 1'b0); pushExpect("lw2_fetch", 0, 4'd0, IRW | PCU, MX_FETCH); checkOutput();
      applyStimulus(OP_LW, 3'd2, 1'b0, 1'b0, 1'b0); pushExpect("lw2_decode", 0, 4'd1, NONE, MX_DECODE); checkOutput();
      applyStimulus(OP_LW, 3'd2, 1'b0, 1'b0, 1'b0); pushExpect("lw2_memadr", 0, 4'd2, NONE, MX_MEMADR); checkOutput();
      applyStimulus(OP_LW, 3'd2, 1'b0, 1'b0, 1'b0); pushExpect("lw2_memread", 0, 4'd3, NONE, MX_MEMACC); checkOutput();
      applyStimulus(OP_LW, 3'd2, 1'b0, 1'b1, 1'b0); reset = 1'b0;
      pushExpect("rst_async", 0, 4'd0, NONE, MX_FETCH); checkOutput();
      applyStimulus(OP_LW, 3'd2, 1'b0, 1'b1, 1'b0); reset = 1'b0;
      pushExpect("rst_hold", 0, 4'd0, NONE, MX_FETCH); checkOutput();
      applyStimulus(OP_LW, 3'd2, 1'b0, 1'b1, 1'b0); pushExpect("rst_release", 0, 4'd0, IRW | PCU, MX_FETCH); checkOutput();

      // sw holding MemWrite through two wait cycles
      resetAll();
      applyStimulus(OP_SW, 3'd2, 1'b0, 1'b1, 1'b0); pushExpect("sw_fetch", 0, 4'd0, IRW | PCU, MX_FETCH); checkOutput();
      applyStimulus(OP_SW, 3'd2, 1'b0, 1'b0, 1'b0); pushExpect("sw_decode", 0, 4'd1, NONE, MX_DECODE); checkOutput();
      applyStimulus(OP_SW, 3'd2, 1'b0, 1'b0, 1'b0); pushExpect("sw_memadr", 0, 4'd2, NONE, MX_MEMADR); checkOutput();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(OP_SW, 3'd2, 1'b0, 1'b0, 1'b0); pushExpect("sw_wait", 0, 4'd5, MW, MX_MEMACC); checkOutput();
      end
      applyStimulus(OP_SW, 3'd2, 1'b0, 1'b1, 1'b0); pushExpect("sw_done", 0, 4'd5, MW | RET, MX_MEMACC); checkOutput();
      applyStimulus(OP_SW, 3'd2, 1'b0, 1'b0, 1'b0); pushExpect("sw_next", 0, 4'd0, NONE, MX_FETCH); checkOutput();

      // mul: unit 0 waits for alu_done, unit 2 (no muldiv) traps
      resetAll();
      applyStimulus(OP_RTYPE, 3'd0, 1'b1, 1'b1, 1'b0);
      pushExpect("mul_fetch", 0, 4'd0, IRW | PCU, MX_FETCH); pushExpect("mul_fetch", 2, 4'd0, IRW | PCU, MX_FETCH); checkOutput();
      applyStimulus(OP_RTYPE, 3'd0, 1'b1, 1'b0, 1'b0);
      pushExpect("mul_decode", 0, 4'd1, NONE, MX_DECODE); pushExpect("mul_decode", 2, 4'd1, NONE, MX_DECODE); checkOutput();
      applyStimulus(OP_RTYPE, 3'd0, 1'b1, 1'b0, 1'b0);
      pushExpect("mul_start", 0, 4'd13, MDS, MX_MULDIV); pushExpect("mul_nomd_trap", 2, 4'd14, TRP, MX_ZERO); checkOutput();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(OP_RTYPE, 3'd0, 1'b1, 1'b0, 1'b0); pushExpect("mul_busy", 0, 4'd13, NONE, MX_MULDIV); checkOutput();
      end
      applyStimulus(OP_RTYPE, 3'd0, 1'b1, 1'b0, 1'b1); pushExpect("mul_done", 0, 4'd13, NONE, MX_MULDIV); checkOutput();
      applyStimulus(OP_RTYPE, 3'd0, 1'b1, 1'b0, 1'b0);
      pushExpect("mul_wb", 0, 4'd7, RW | RET, MX_ZERO); pushExpect("mul_nomd_hold", 2, 4'd14, TRP, MX_ZERO); checkOutput();
      applyStimulus(OP_RTYPE, 3'd0, 1'b1, 1'b0, 1'b0); pushExpect("mul_next", 0, 4'd0, NONE, MX_FETCH); checkOutput();

      // mul with alu_done already high in the first MULDIV cycle
      applyStimulus(OP_RTYPE, 3'd0, 1'b1, 1'b1, 1'b0); pushExpect("mul1_fetch", 0, 4'd0, IRW | PCU, MX_FETCH); checkOutput();
      applyStimulus(OP_RTYPE, 3'd0, 1'b1, 1'b0, 1'b0); pushExpect("mul1_decode", 0, 4'd1, NONE, MX_DECODE); checkOutput();
      applyStimulus(OP_RTYPE, 3'd0, 1'b1, 1'b0, 1'b1); pushExpect("mul1_start", 0, 4'd13, MDS, MX_MULDIV); checkOutput();
      applyStimulus(OP_RTYPE, 3'd0, 1'b1, 1'b0, 1'b0); pushExpect("mul1_wb", 0, 4'd7, RW | RET, MX_ZERO); checkOutput();

      // jalr, jal, bge, lui, auipc, addi, illegal branch on unit 0
      resetAll();
      applyStimulus(OP_JALR, 3'd0, 1'b0, 1'b1, 1'b0); pushExpect("jalr_fetch", 0, 4'd0, IRW | PCU, MX_FETCH); checkOutput();
      applyStimulus(OP_JALR, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("jalr_decode", 0, 4'd1, NONE, MX_DECODE); checkOutput();
      applyStimulus(OP_JALR, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("jalr_pc", 0, 4'd12, PCU, MX_JALR); checkOutput();
      applyStimulus(OP_JALR, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("jalr_link", 0, 4'd15, RW | RET, MX_LINK); checkOutput();
      applyStimulus(OP_JALR, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("jalr_next", 0, 4'd0, NONE, MX_FETCH); checkOutput();

      applyStimulus(OP_JAL, 3'd0, 1'b0, 1'b1, 1'b0); pushExpect("jal_fetch", 0, 4'd0, IRW | PCU, MX_FETCH); checkOutput();
      applyStimulus(OP_JAL, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("jal_decode", 0, 4'd1, NONE, MX_DECODE); checkOutput();
      applyStimulus(OP_JAL, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("jal_pc", 0, 4'd9, PCU, MX_JAL); checkOutput();
      applyStimulus(OP_JAL, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("jal_wb", 0, 4'd7, RW | RET, MX_ZERO); checkOutput();

      applyStimulus(OP_BRANCH, 3'b101, 1'b0, 1'b1, 1'b0); pushExpect("bge_fetch", 0, 4'd0, IRW | PCU, MX_FETCH); checkOutput();
      applyStimulus(OP_BRANCH, 3'b101, 1'b0, 1'b0, 1'b0); pushExpect("bge_decode", 0, 4'd1, NONE, MX_DECODE); checkOutput();
      applyStimulus(OP_BRANCH, 3'b101, 1'b0, 1'b0, 1'b0); pushExpect("bge_branch", 0, 4'd10, BR | RET, MX_BGE); checkOutput();
      applyStimulus(OP_BRANCH, 3'b101, 1'b0, 1'b0, 1'b0); pushExpect("bge_next", 0, 4'd0, NONE, MX_FETCH); checkOutput();

      applyStimulus(OP_LUI, 3'd0, 1'b0, 1'b1, 1'b0); pushExpect("lui_fetch", 0, 4'd0, IRW | PCU, MX_FETCH); checkOutput();
      applyStimulus(OP_LUI, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("lui_decode", 0, 4'd1, NONE, MX_DECODE); checkOutput();
      applyStimulus(OP_LUI, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("lui_utype", 0, 4'd11, NONE, MX_LUI); checkOutput();
      applyStimulus(OP_LUI, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("lui_wb", 0, 4'd7, RW | RET, MX_ZERO); checkOutput();

      applyStimulus(OP_AUIPC, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("auipc_wait", 0, 4'd0, NONE, MX_FETCH); checkOutput();
      applyStimulus(OP_AUIPC, 3'd0, 1'b0, 1'b1, 1'b0); pushExpect("auipc_fetch", 0, 4'd0, IRW | PCU, MX_FETCH); checkOutput();
      applyStimulus(OP_AUIPC, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("auipc_decode", 0, 4'd1, NONE, MX_DECODE); checkOutput();
      applyStimulus(OP_AUIPC, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("auipc_utype", 0, 4'd11, NONE, MX_AUIPC); checkOutput();
      applyStimulus(OP_AUIPC, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("auipc_wb", 0, 4'd7, RW | RET, MX_ZERO); checkOutput();

      applyStimulus(OP_ITYPE, 3'd0, 1'b0, 1'b1, 1'b0); pushExpect("addi_fetch", 0, 4'd0, IRW | PCU, MX_FETCH); checkOutput();
      applyStimulus(OP_ITYPE, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("addi_decode", 0, 4'd1, NONE, MX_DECODE); checkOutput();
      applyStimulus(OP_ITYPE, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("addi_execi", 0, 4'd8, NONE, MX_EXECI); checkOutput();
      applyStimulus(OP_ITYPE, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("addi_wb", 0, 4'd7, RW | RET, MX_ZERO); checkOutput();

      applyStimulus(OP_BRANCH, 3'b011, 1'b0, 1'b1, 1'b0); pushExpect("bad_br_fetch", 0, 4'd0, IRW | PCU, MX_FETCH); checkOutput();
      applyStimulus(OP_BRANCH, 3'b011, 1'b0, 1'b0, 1'b0); pushExpect("bad_br_decode", 0, 4'd1, NONE, MX_DECODE); checkOutput();
      applyStimulus(OP_BRANCH, 3'b011, 1'b0, 1'b1, 1'b0); pushExpect("bad_br_trap", 0, 4'd14, TRP, MX_ZERO); checkOutput();

      // add with single-cycle memory (unit 1), then an illegal opcode on units 0-2
      resetAll();
      applyStimulus(OP_RTYPE, 3'd0, 1'b0, 1'b0, 1'b0);
      pushExpect("add_fetch", 1, 4'd0, IRW | PCU, MX_FETCH); pushExpect("add_nomem", 0, 4'd0, NONE, MX_FETCH); checkOutput();
      applyStimulus(OP_RTYPE, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("add_decode", 1, 4'd1, NONE, MX_DECODE); checkOutput();
      applyStimulus(OP_RTYPE, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("add_execr", 1, 4'd6, NONE, MX_EXECR); checkOutput();
      applyStimulus(OP_RTYPE, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("add_wb", 1, 4'd7, RW | RET, MX_ZERO); checkOutput();
      applyStimulus(OP_ILL, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("add_next", 1, 4'd0, IRW | PCU, MX_FETCH); checkOutput();
      applyStimulus(OP_ILL, 3'd0, 1'b0, 1'b0, 1'b0);
      pushExpect("ill_decode", 1, 4'd1, NONE, MX_DECODE); pushExpect("ill_decode", 2, 4'd1, NONE, MX_DECODE); checkOutput();
      applyStimulus(OP_ILL, 3'd0, 1'b0, 1'b0, 1'b0);
      pushExpect("ill_nop", 1, 4'd0, IRW | PCU, MX_FETCH); pushExpect("ill_trap", 2, 4'd14, TRP, MX_ZERO);
      pushExpect("ill_idle", 0, 4'd0, NONE, MX_FETCH); checkOutput();

      // illegal opcode on unit 0 stays trapped for 20 cycles whatever the inputs
      resetAll();
      applyStimulus(OP_ILL, 3'd0, 1'b0, 1'b1, 1'b0); pushExpect("trap_fetch", 0, 4'd0, IRW | PCU, MX_FETCH); checkOutput();
      applyStimulus(OP_ILL, 3'd0, 1'b0, 1'b0, 1'b0); pushExpect("trap_decode", 0, 4'd1, NONE, MX_DECODE); checkOutput();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(OP_ILL, 3'($urandom_range(7)), 1'($urandom_range(1)),
                       1'($urandom_range(1)), 1'($urandom_range(1)));
         pushExpect("trap_hold", 0, 4'd14, TRP, MX_ZERO);
         checkOutput();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
